// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: hazard sequencer state encoding and common constants.
package pipeline_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    DRAIN    = 2'd2,
    HALTED   = 2'd3
  } seq_state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // EX, MEM and WB must retire before the halt is complete.
  localparam int DRAIN_CYCLES_DEF = 3;

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (inc && (cnt != {W{1'b1}})) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/hazard_sequencer.sv
// Pipeline sequencer: load-use/control hazard handling, memory-wait freeze,
// halt drain and saturating stall/flush performance counters.
module hazard_sequencer
  import pipeline_pkg::*;
#(
  parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic             id_halt,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rd,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             pipe_hold,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int DW = (DRAIN_CYCLES > 2) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_CYCLES - 1);

  seq_state_t    state, state_nxt;
  seq_state_t    saved, saved_nxt;
  seq_state_t    eff_state;
  logic [DW-1:0] drain_cnt, drain_nxt;
  logic          mw, lu;
  logic          stall_inc, flush_inc;

  assign mw = mem_req & ~mem_ready;
  assign lu = ex_mem_read & (ex_rd != REG_ZERO) &
              ((id_uses_rs1 & (id_rs1 == ex_rd)) | (id_uses_rs2 & (id_rs2 == ex_rd)));

  // The cycle that ends a memory wait behaves like the state we left, so a
  // drain keeps counting and pending RUN hazards are evaluated as usual.
  assign eff_state = (state == MEM_WAIT) ? saved : state;

  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    pipe_hold    = 1'b0;
    halted       = 1'b0;
    flush_inc    = 1'b0;
    state_nxt    = state;
    saved_nxt    = saved;
    drain_nxt    = drain_cnt;
    if (rst_n) begin
      if (state == HALTED) begin
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        id_ex_bubble = 1'b1;
        pipe_hold    = 1'b1;
        halted       = 1'b1;
      end else if (mw) begin
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        pipe_hold   = 1'b1;
        state_nxt   = MEM_WAIT;
        saved_nxt   = eff_state;
      end else if (eff_state == DRAIN) begin
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        id_ex_bubble = 1'b1;
        drain_nxt    = (drain_cnt == '0) ? '0 : drain_cnt - DW'(1);
        state_nxt    = (drain_cnt <= DW'(1)) ? HALTED : DRAIN;
      end else begin
        state_nxt = RUN;
        if (ex_branch_taken) begin
          if_id_flush  = 1'b1;
          id_ex_bubble = 1'b1;
          flush_inc    = 1'b1;
        end else if (lu) begin
          pc_write     = 1'b0;
          if_id_write  = 1'b0;
          id_ex_bubble = 1'b1;
        end else if (id_halt) begin
          pc_write     = 1'b0;
          if_id_write  = 1'b0;
          id_ex_bubble = 1'b1;
          drain_nxt    = DRAIN_LOAD;
          state_nxt    = (DRAIN_CYCLES <= 1) ? HALTED : DRAIN;
        end
      end
    end
  end

  assign stall_inc = rst_n & ~pc_write & (state != HALTED);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      saved     <= RUN;
      drain_cnt <= '0;
    end else begin
      state     <= state_nxt;
      saved     <= saved_nxt;
      drain_cnt <= drain_nxt;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (stall_inc),
    .cnt   (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (flush_inc),
    .cnt   (flush_cnt)
  );

endmodule

// File: tb/tb_hazard_sequencer.sv
// Scoreboard bench for hazard_sequencer: a behavioural model queues the
// expected outputs per driven cycle, which are popped and compared mid-cycle.
module tb_hazard_sequencer;

  localparam int CNT_W = 8;
  localparam int DC    = 3;
  localparam int MAXC  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [4:0]       id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic             id_uses_rs1 = 1'b0, id_uses_rs2 = 1'b0, id_halt = 1'b0;
  logic             ex_mem_read = 1'b0, ex_branch_taken = 1'b0;
  logic             mem_req = 1'b0, mem_ready = 1'b0;
  logic             pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_hold, halted;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  hazard_sequencer #(.DRAIN_CYCLES(DC), .CNT_W(CNT_W)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .id_uses_rs1     (id_uses_rs1),
    .id_uses_rs2     (id_uses_rs2),
    .id_halt         (id_halt),
    .ex_mem_read     (ex_mem_read),
    .ex_rd           (ex_rd),
    .ex_branch_taken (ex_branch_taken),
    .mem_req         (mem_req),
    .mem_ready       (mem_ready),
    .pc_write        (pc_write),
    .if_id_write     (if_id_write),
    .if_id_flush     (if_id_flush),
    .id_ex_bubble    (id_ex_bubble),
    .pipe_hold       (pipe_hold),
    .halted          (halted),
    .stall_cnt       (stall_cnt),
    .flush_cnt       (flush_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic             pcw;
    logic             ifw;
    logic             fl;
    logic             bub;
    logic             hold;
    logic             hlt;
    logic [CNT_W-1:0] sc;
    logic [CNT_W-1:0] fc;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_err    = 0;

  // Model state: 0 RUN, 1 MEM_WAIT, 2 DRAIN, 3 HALTED
  int m_state = 0, m_saved = 0, m_cnt = 0, m_stall = 0, m_flush = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_saved = 0; m_cnt = 0; m_stall = 0; m_flush = 0;
  endtask

  task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                       input logic u2, input logic hl, input logic emr, input logic [4:0] erd,
                       input logic br, input logic mreq, input logic mrdy);
    exp_t e;
    int   nstate, nsaved, ncnt, eff;
    logic mw, lu, finc;
    id_rs1 = rs1; id_rs2 = rs2; id_uses_rs1 = u1; id_uses_rs2 = u2; id_halt = hl;
    ex_mem_read = emr; ex_rd = erd; ex_branch_taken = br; mem_req = mreq; mem_ready = mrdy;
    mw   = mreq && !mrdy;
    lu   = emr && (erd != 5'd0) && ((u1 && rs1 == erd) || (u2 && rs2 == erd));
    finc = 1'b0;
    e.pcw = 1'b1; e.ifw = 1'b1; e.fl = 1'b0; e.bub = 1'b0; e.hold = 1'b0; e.hlt = 1'b0;
    e.sc = CNT_W'(m_stall); e.fc = CNT_W'(m_flush);
    nstate = m_state; nsaved = m_saved; ncnt = m_cnt;
    eff = (m_state == 1) ? m_saved : m_state;
    if (m_state == 3) begin
      e.pcw = 1'b0; e.ifw = 1'b0; e.bub = 1'b1; e.hold = 1'b1; e.hlt = 1'b1;
    end else if (mw) begin
      e.pcw = 1'b0; e.ifw = 1'b0; e.hold = 1'b1; nstate = 1; nsaved = eff;
    end else if (eff == 2) begin
      e.pcw = 1'b0; e.ifw = 1'b0; e.bub = 1'b1;
      ncnt = m_cnt - 1; nstate = (ncnt <= 0) ? 3 : 2;
    end else begin
      nstate = 0;
      if (br) begin
        e.fl = 1'b1; e.bub = 1'b1; finc = 1'b1;
      end else if (lu) begin
        e.pcw = 1'b0; e.ifw = 1'b0; e.bub = 1'b1;
      end else if (hl) begin
        e.pcw = 1'b0; e.ifw = 1'b0; e.bub = 1'b1;
        ncnt = DC - 1; nstate = (DC == 1) ? 3 : 2;
      end
    end
    sb_q.push_back(e);
    @(negedge clk);
    e = sb_q.pop_front();
    check("pc_write",     32'(pc_write),     32'(e.pcw));
    check("if_id_write",  32'(if_id_write),  32'(e.ifw));
    check("if_id_flush",  32'(if_id_flush),  32'(e.fl));
    check("id_ex_bubble", 32'(id_ex_bubble), 32'(e.bub));
    check("pipe_hold",    32'(pipe_hold),    32'(e.hold));
    check("halted",       32'(halted),       32'(e.hlt));
    check("stall_cnt",    32'(stall_cnt),    32'(e.sc));
    check("flush_cnt",    32'(flush_cnt),    32'(e.fc));
    @(posedge clk);
    if (!e.pcw && m_state != 3 && m_stall < MAXC) m_stall++;
    if (finc && m_flush < MAXC) m_flush++;
    m_state = nstate; m_saved = nsaved; m_cnt = ncnt;
    #1;
  endtask

  task automatic idle();
    drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic mem_wait();
    drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic halt_req();
    drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  // Asynchronous reset pulse away from any clock edge; current inputs stay applied while low.
  task automatic rst_check(input string tag);
    rst_n = 1'b0;
    #2;
    check({tag, "_pc_write"},    32'(pc_write),     32'd1);
    check({tag, "_if_id_write"}, 32'(if_id_write),  32'd1);
    check({tag, "_flush"},       32'(if_id_flush),  32'd0);
    check({tag, "_bubble"},      32'(id_ex_bubble), 32'd0);
    check({tag, "_hold"},        32'(pipe_hold),    32'd0);
    check({tag, "_halted"},      32'(halted),       32'd0);
    check({tag, "_stall_cnt"},   32'(stall_cnt),    32'd0);
    check({tag, "_flush_cnt"},   32'(flush_cnt),    32'd0);
    id_rs1 = '0; id_rs2 = '0; id_uses_rs1 = 0; id_uses_rs2 = 0; id_halt = 0;
    ex_mem_read = 0; ex_rd = '0; ex_branch_taken = 0; mem_req = 0; mem_ready = 0;
    rst_n = 1'b1;
    #1;
    model_reset();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    // Hazard inputs present during reset must not leak to the outputs.
    id_rs1 = 5'd5; id_uses_rs1 = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd5; id_halt = 1'b1;
    @(posedge clk);
    #1;
    rst_check("rst_init");

    // Load-use: lw x5 in EX, add x6,x5,x1 in ID
    drive(5'd5, 5'd1, 1'b1, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
    check("lu_stall_cnt", 32'(stall_cnt), 32'd1);
    drive(5'd5, 5'd1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0);
    drive(5'd0, 5'd1, 1'b1, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    check("lu_x0_stall_cnt", 32'(stall_cnt), 32'd1);
    drive(5'd1, 5'd7, 1'b1, 1'b1, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0);
    drive(5'd1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0);
    check("lu_rs2_stall_cnt", 32'(stall_cnt), 32'd2);

    // Taken branch overrides load-use
    drive(5'd5, 5'd1, 1'b1, 1'b1, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
    check("br_flush_cnt", 32'(flush_cnt), 32'd1);
    check("br_stall_cnt", 32'(stall_cnt), 32'd2);

    // Three memory wait cycles, then completion and a same-cycle-ready access
    mem_wait(); mem_wait(); mem_wait();
    drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
    drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
    check("mw_stall_cnt", 32'(stall_cnt), 32'd5);

    // Halt on the wrong path is cancelled by the branch
    drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
    idle();
    check("hc_halted", 32'(halted), 32'd0);
    check("hc_flush_cnt", 32'(flush_cnt), 32'd2);

    // Halt latency: DRAIN_CYCLES cycles after acceptance
    halt_req();
    idle();
    check("halt_early", 32'(halted), 32'd0);
    idle();
    check("halt_on_time", 32'(halted), 32'd1);
    idle(); idle();
    rst_check("rst_after_halt");

    // Halt with two wait cycles mid-drain
    halt_req();
    mem_wait(); mem_wait();
    idle();
    check("halt_mw_early", 32'(halted), 32'd0);
    idle();
    check("halt_mw_on_time", 32'(halted), 32'd1);
    rst_check("rst_halted");

    // Reset mid-drain
    halt_req();
    idle();
    rst_check("rst_mid_drain");
    idle();

    // Reset mid-memory-wait
    mem_wait(); mem_wait();
    rst_check("rst_mid_mw");
    idle();

    // Saturation of both counters
    for (int i = 0; i < MAXC + 6; i++)
      drive(5'd5, 5'd1, 1'b1, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
    check("sat_stall_cnt", 32'(stall_cnt), 32'(MAXC));
    for (int i = 0; i < MAXC + 6; i++)
      drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
    check("sat_flush_cnt", 32'(flush_cnt), 32'(MAXC));
    check("sat_stall_hold", 32'(stall_cnt), 32'(MAXC));
    rst_check("rst_sat");

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      logic br;
      if (i % 40 == 39) rst_check("rst_rand");
      br = ($urandom_range(7) == 0);
      if (m_state == 2 || (m_state == 1 && m_saved == 2)) br = 1'b0;
      drive(5'($urandom_range(7)), 5'($urandom_range(7)), 1'($urandom_range(1)),
            1'($urandom_range(1)), ($urandom_range(15) == 0), 1'($urandom_range(1)),
            5'($urandom_range(7)), br, 1'($urandom_range(1)), 1'($urandom_range(1)));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/hazard_sequencer.md
# hazard_sequencer

Sequences the 5-stage RV32I pipeline around the per-opcode decode controller. It detects load-use and control hazards and freezes the pipeline on data-memory wait states. It drains the pipeline after a decoded `Halt`. It drives the PC/pipeline-register enables, flush and bubble controls, and two saturating performance counters, and sits beside the ID-stage decoder in the top-level datapath.

## Interface
- `DRAIN_CYCLES`, 3: cycles from halt detection in ID until the halt instruction's predecessors have retired (EX, MEM, WB).
- `CNT_W`, 16: width of the performance counters.

- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `id_rs1`, `id_rs2`  in  5 each  source registers of the instruction in ID.
- `id_uses_rs1`, `id_uses_rs2`  in  1 each  the ID instruction reads that source.
- `id_halt`  in  1  decoder `Halt` for the ID instruction.
- `ex_mem_read`  in  1  EX instruction is a load.
- `ex_rd`  in  5  destination register of the EX instruction.
- `ex_branch_taken`  in  1  EX resolved a taken branch or jump.
- `mem_req`  in  1  MEM stage is accessing data memory.
- `mem_ready`  in  1  data memory completes the access this cycle.
- `pc_write`  out  1  PC register enable.
- `if_id_write`  out  1  IF/ID register enable.
- `if_id_flush`  out  1  load NOP into IF/ID.
- `id_ex_bubble`  out  1  load NOP into ID/EX.
- `pipe_hold`  out  1  hold ID/EX, EX/MEM and MEM/WB; suppress register-file write.
- `halted`  out  1  pipeline fully drained after halt.
- `stall_cnt`  out  `CNT_W`  cycles with any stall or freeze.
- `flush_cnt`  out  `CNT_W`  taken-branch flush events.

## Operation
- FSM states: RUN, MEM_WAIT, DRAIN, HALTED. Reset state is RUN.
- Hazard conditions:
  - `mw = mem_req & !mem_ready`
  - `lu = ex_mem_read & ex_rd != 0 & ((id_uses_rs1 & id_rs1 == ex_rd) | (id_uses_rs2 & id_rs2 == ex_rd))`
- RUN and DRAIN apply the following in priority order:
  1. `mw`: freeze. All of `pc_write`, `if_id_write` and `id_ex_bubble` are 0, and `pipe_hold` is 1. Go to MEM_WAIT and keep the DRAIN count.
  2. `ex_branch_taken`: `if_id_flush` = 1 and `id_ex_bubble` = 1, with the PC written. This overrides `lu` and cancels `id_halt` (the halt is on the wrong path). `flush_cnt` increments.
  3. `lu` (RUN only): `pc_write` = 0, `if_id_write` = 0, `id_ex_bubble` = 1 for exactly one cycle.
  4. `id_halt` (RUN only): `pc_write` = 0, `if_id_write` = 0, `id_ex_bubble` = 1. Load the drain counter with `DRAIN_CYCLES - 1` and go to DRAIN.
- MEM_WAIT:
  - Outputs are frozen as in rule 1 while `mw` holds.
  - When `mem_ready` arrives, return to the state saved on entry (RUN or DRAIN).
  - Pending branch, load-use or halt conditions are re-evaluated on the next cycle; the pipeline registers did not move, so no event is lost.
- DRAIN:
  - `pc_write` = 0, `if_id_write` = 0, `id_ex_bubble` = 1.
  - The counter decrements on each non-frozen cycle; at 0 go to HALTED.
  - `ex_branch_taken` cannot occur in DRAIN because EX holds a bubble; treat it as don't-care.
- HALTED:
  - `halted` = 1, `pc_write` = 0, `if_id_write` = 0, `id_ex_bubble` = 1, `pipe_hold` = 1.
  - Only `rst_n` leaves this state.
- Counters:
  - `stall_cnt` increments on every cycle in which `pc_write` = 0, excluding HALTED.
  - Both counters saturate at all-ones and never wrap.
- Defaults when no rule applies: `pc_write` = 1, `if_id_write` = 1, all other outputs 0.

## Timing
- Hazard outputs are combinational (Mealy) from the current state and inputs, with zero-cycle latency. The state, drain counter and perf counters are registered.
- Reset (asynchronous, any time, including mid-DRAIN or mid-MEM_WAIT):
  - State goes to RUN; drain counter, `stall_cnt` and `flush_cnt` go to 0; `halted` = 0.
  - While `rst_n` = 0 the outputs are `pc_write` = 1, `if_id_write` = 1, and all others 0.
- Load-use stall is exactly one cycle; the following cycle sees a bubble in EX, so `lu` is false.
- Halt latency: `halted` rises `DRAIN_CYCLES` non-frozen cycles after the cycle in which `id_halt` is accepted. Each MEM_WAIT cycle adds one.
- A `mem_req` with `mem_ready` = 1 in the same cycle causes no stall.

## Structure
- Shared package `pipeline_pkg`:
  - enum `seq_state_t` {RUN, MEM_WAIT, DRAIN, HALTED}
  - constant `REG_ZERO = 5'd0`
  - default `DRAIN_CYCLES` value
- One natural sub-module, `sat_counter` (parameter width; inputs `inc`, `clk`, `rst_n`), instantiated twice for the perf counters.
- The hazard detection and FSM stay in the top module.

## Test plan
- Load-use: EX holds `lw x5` (`ex_mem_read` = 1, `ex_rd` = 5); ID holds `add x6,x5,x1`.
  - Required: one cycle with `pc_write` = 0 and `id_ex_bubble` = 1; `stall_cnt` = 1. With `ex_rd` = 0 there is no stall.
- Branch plus load-use: `ex_branch_taken` = 1 with `lu` true.
  - Required: `if_id_flush` = 1, `id_ex_bubble` = 1, `pc_write` = 1; `flush_cnt` = 1; `stall_cnt` unchanged.
- Memory wait: `mem_req` = 1 with `mem_ready` = 0 for 3 cycles.
  - Required: 3 cycles of `pipe_hold` = 1 with `pc_write` = 0, then resume in RUN; `stall_cnt` = 3.
- Halt: `id_halt` = 1 in RUN with `DRAIN_CYCLES` = 3.
  - Required: `halted` = 1 exactly 3 cycles later. With 2 wait cycles injected mid-drain, `halted` rises at 5 cycles.
- Halt cancelled: `id_halt` = 1 together with `ex_branch_taken` = 1.
  - Required: flush only, state stays RUN, `halted` stays 0.
- Reset: drop `rst_n` mid-DRAIN, then again with counters at all-ones.
  - Required: immediate return to RUN, counters 0, `halted` = 0. Separately, forcing 2^`CNT_W` + 5 stalls leaves `stall_cnt` saturated at all-ones.
